// File: rtl/chi_slice_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chi_slice_engine_pkg
// Description : Shared constants, FSM state type and slice/row helpers for
//               the chi slice engine.
// Revision    : 1.0 - initial release
// ============================================================================
package chi_slice_engine_pkg;

    localparam int CELLS = 25;
    localparam int ROW_W = 5;
    localparam int ROWS  = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_e;

    // Cell (x,y) lives at bit 24-(5*y+x), so x=0 is the MSB of its row.
    function automatic logic [4:0] cell_idx(input int x, input int y);
        return 5'(24 - (5 * y + x));
    endfunction

    // Extract row y as a vector indexed by x.
    function automatic logic [ROW_W-1:0] get_row(input logic [CELLS-1:0] s,
                                                 input logic [2:0]       y);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int x = 0; x < ROW_W; x++) begin
            r[x] = s[cell_idx(x, int'(y))];
        end
        return r;
    endfunction

    function automatic logic [CELLS-1:0] put_row(input logic [CELLS-1:0] s,
                                                 input logic [2:0]       y,
                                                 input logic [ROW_W-1:0] r);
        logic [CELLS-1:0] o;
        o = s;
        for (int x = 0; x < ROW_W; x++) begin
            o[cell_idx(x, int'(y))] = r[x];
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chi_slice_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : chi_slice_engine_if
// Description : Input and output slice streams of the chi slice engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface chi_slice_engine_if;

    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_slice;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_slice;
    logic        out_last;
    logic        frame_done;

    modport master (
        output in_valid, in_slice, out_ready,
        input  in_ready, out_valid, out_slice, out_last, frame_done
    );

    modport slave (
        input  in_valid, in_slice, out_ready,
        output in_ready, out_valid, out_slice, out_last, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/chi_slice_engine_row.sv
`default_nettype none
// ============================================================================
// Module      : chi_row
// Description : Combinational chi on one 5-cell row, bit x = cell x.
// Revision    : 1.0 - initial release
// ============================================================================
module chi_row (
    input  logic [4:0] a_i,
    output logic [4:0] b_o
);

    for (genvar x = 0; x < 5; x++) begin : g_bit
        assign b_o[x] = a_i[x] ^ (~a_i[(x + 1) % 5] & a_i[(x + 2) % 5]);
    end

endmodule
`default_nettype wire

// File: rtl/chi_slice_engine.sv
`default_nettype none
// ============================================================================
// Module      : chi_slice_engine
// Description : Streaming row-parallel Keccak chi on 25-bit slices with an
//               output FIFO and frame tracking. Define CHI_IOTA_EN to fold
//               iota (rc[z] into cell 0,0) into the result.
// Revision    : 1.0 - initial release
// ============================================================================
module chi_slice_engine
    import chi_slice_engine_pkg::*;
#(
    parameter int NUM_SLICES   = 64,
    parameter int ROWS_PER_CYC = 1,
    parameter int OBUF_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [NUM_SLICES-1:0] rc,
    chi_slice_engine_if.slave     io
);

    localparam int              ZW       = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int              AW       = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int              CW       = AW + 1;
    localparam logic [2:0]      LAST_ROW = 3'(ROWS - ROWS_PER_CYC);
    localparam logic [2:0]      ROW_STEP = 3'(ROWS_PER_CYC);
    localparam logic [ZW-1:0]   Z_MAX    = ZW'(NUM_SLICES - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(OBUF_DEPTH);

    state_e                state_q, state_d;
    logic [2:0]            row_cnt_q, row_cnt_d;
    logic [ZW-1:0]         z_q, z_d;
    logic [CELLS-1:0]      work_q;
    logic [CELLS-1:0]      result_q, result_d;
    logic                  frame_done_q;

    logic [CELLS:0]        fifo_mem_q [OBUF_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         cnt_q;

    logic                  w_full, w_empty, w_pop, w_space;
    logic                  w_in_ready, w_accept;
    logic                  w_push, w_last, w_iota;
    logic [ZW-1:0]         w_z_next;
    logic [CELLS-1:0]      w_merged, w_push_data;
    logic [CELLS:0]        w_head;
    logic [2:0]            w_row_y   [ROWS_PER_CYC];
    logic [ROW_W-1:0]      w_row_in  [ROWS_PER_CYC];
    logic [ROW_W-1:0]      w_row_out [ROWS_PER_CYC];

    // ------------------------------------------------------------------
    // Handshake and FIFO status
    // ------------------------------------------------------------------
    assign w_full     = (cnt_q == FULL_CNT);
    assign w_empty    = (cnt_q == '0);
    assign w_pop      = ~w_empty & io.out_ready;
    assign w_space    = ~w_full | w_pop;
    // Gating with rst keeps in_ready low for the whole reset window.
    assign w_in_ready = rst & (state_q == IDLE) & ~flush & ~w_full;
    assign w_accept   = io.in_valid & w_in_ready;
    assign w_last     = (z_q == Z_MAX);
    assign w_z_next   = w_last ? '0 : z_q + ZW'(1);
    assign w_head     = fifo_mem_q[rd_ptr_q];

    assign io.in_ready   = w_in_ready;
    assign io.out_valid  = ~w_empty;
    assign io.out_slice  = w_empty ? '0 : w_head[CELLS-1:0];
    assign io.out_last   = ~w_empty & w_head[CELLS];
    assign io.frame_done = frame_done_q;

    // ------------------------------------------------------------------
    // Row datapath: ROWS_PER_CYC chi rows starting at row_cnt
    // ------------------------------------------------------------------
    for (genvar k = 0; k < ROWS_PER_CYC; k++) begin : g_rows
        assign w_row_y[k]  = row_cnt_q + 3'(k);
        assign w_row_in[k] = get_row(work_q, w_row_y[k]);
        chi_row u_chi_row (
            .a_i (w_row_in[k]),
            .b_o (w_row_out[k])
        );
    end

`ifdef CHI_IOTA_EN
    logic [NUM_SLICES-1:0] rc_q;

    // rc is captured once per frame, on the accept of slice 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rc_q <= '0;
        end else if (w_accept && (z_q == '0)) begin
            rc_q <= rc;
        end
    end

    assign w_iota = rc_q[z_q];
`else
    logic w_unused_rc;
    assign w_unused_rc = ^rc;
    assign w_iota      = 1'b0;
`endif

    always_comb begin
        w_merged = result_q;
        for (int k = 0; k < ROWS_PER_CYC; k++) begin
            w_merged = put_row(w_merged, w_row_y[k],
                               w_row_out[k] ^ {4'b0000, w_iota & (w_row_y[k] == 3'd0)});
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        result_d    = result_q;
        z_d         = z_q;
        w_push      = 1'b0;
        w_push_data = result_q;

        unique case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d   = COMPUTE;
                    row_cnt_d = 3'd0;
                end
            end
            COMPUTE: begin
                result_d = w_merged;
                if (row_cnt_q == LAST_ROW) begin
                    if (w_space) begin
                        w_push      = 1'b1;
                        w_push_data = w_merged;
                        z_d         = w_z_next;
                        state_d     = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    row_cnt_d = row_cnt_q + ROW_STEP;
                end
            end
            HOLD: begin
                if (w_space) begin
                    w_push  = 1'b1;
                    z_d     = w_z_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d   = IDLE;
            row_cnt_d = 3'd0;
            z_d       = '0;
            w_push    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            row_cnt_q    <= 3'd0;
            z_q          <= '0;
            work_q       <= '0;
            result_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            z_q          <= z_d;
            result_q     <= result_d;
            frame_done_q <= ~flush & w_pop & w_head[CELLS];
            if (w_accept) begin
                work_q <= io.in_slice;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO; entries are {last, slice}
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= {w_last, w_push_data};
        end
    end

endmodule
`default_nettype wire
